proc_issue_seq: RTL and testbench

Instruction issue sequencer for the `proc` datapath. It accepts 32-bit instruction words from a producer over a valid/ready handshake into a small FIFO. It drives `proc`'s `instr` input with at most one instruction per clock, inserting NOP bubbles whenever a register-source instruction would read a destination register that is still in flight. It sits directly in front of `proc`; `instr_out` connects straight to the `proc` `instr` port.

---
 rtl/proc_pkg.sv | 13 +
 rtl/proc_issue_seq_if.sv | 10 +
 rtl/sync_fifo.sv | 36 +++
 rtl/proc_issue_seq.sv | 100 ++++++++++
 tb/tb_proc_issue_seq.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/proc_pkg.sv
// proc_pkg: opcodes, instruction word fields and FSM encoding shared by the issue sequencer
package proc_pkg;
  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_ADDI = 8'h01;
  localparam logic [7:0] OP_ADDR = 8'h02;
  localparam logic [7:0] OP_NOP = 8'hFF;
  localparam logic [31:0] NOP_WORD = 32'hFF00_0000;
  localparam int OP_LSB = 24;
  localparam int DST_LSB = 16;
  localparam int SRCA_LSB = 8;
  localparam int SRCB_LSB = 0;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STALL} state_e;
endpackage

// File: rtl/proc_issue_seq_if.sv
// proc_issue_seq_if: producer handshake and issue bus of the sequencer
interface proc_issue_seq_if;
  logic [31:0] in_instr;
  logic in_valid;
  logic in_ready;
  logic [31:0] instr_out;
  logic issue_valid;
  modport master (output in_instr, in_valid, input in_ready, instr_out, issue_valid);
  modport slave (input in_instr, in_valid, output in_ready, instr_out, issue_valid);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two FIFO; pointers carry one extra bit to tell full from empty
module sync_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic do_push, do_pop;
  assign empty = wr_q == rd_q;
  assign full = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign dout = mem[rd_q[AW-1:0]];
  // Storage write; no bypass, so a pushed word reaches the head a cycle later
  always_ff @(posedge clk)
    if (do_push) mem[wr_q[AW-1:0]] <= din;
  // Pointers roll over naturally modulo 2*DEPTH
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_q + {{AW{1'b0}}, do_push};
      rd_q <= rd_q + {{AW{1'b0}}, do_pop};
    end
endmodule

// File: rtl/proc_issue_seq.sv
// proc_issue_seq: queues instruction words and issues them to proc, inserting bubbles on RAW hazards
module proc_issue_seq
  import proc_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int HAZARD_CYCLES = 2,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic halt,
  proc_issue_seq_if.slave bus,
  output logic busy,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] stall_cnt
);
  logic [31:0] head, instr_d, instr_q;
  logic full, empty, pop, valid_d, valid_q, haz, stall_inc, rd_a, rd_b;
  logic [7:0] op, src_a, src_b;
  state_e state_d, state_q;
  logic [HAZARD_CYCLES-1:0] trk_v_q;
  logic [7:0] trk_r_q [HAZARD_CYCLES];
  logic [CNT_W-1:0] iss_q, stl_q;

  sync_fifo #(.W(32), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(bus.in_valid), .pop(pop), .din(bus.in_instr),
    .dout(head), .full(full), .empty(empty)
  );

  assign bus.in_ready = ~full;
  assign bus.instr_out = instr_q;
  assign bus.issue_valid = valid_q;
  assign busy = state_q != S_IDLE;
  assign issued_cnt = iss_q;
  assign stall_cnt = stl_q;
  assign op = head[OP_LSB +: 8];
  assign src_a = head[SRCA_LSB +: 8];
  assign src_b = head[SRCB_LSB +: 8];
  assign rd_a = (op == OP_ADDI) | (op == OP_ADDR);
  assign rd_b = op == OP_ADDR;

  // Head hazards when a register it reads matches any dest still in flight
  always_comb begin
    haz = 1'b0;
    for (int i = 0; i < HAZARD_CYCLES; i++)
      haz = haz | (trk_v_q[i] & ((rd_a & (trk_r_q[i] == src_a)) | (rd_b & (trk_r_q[i] == src_b))));
  end

  // Next state, issue word and pop decision; halt beats start and always yields a bubble
  always_comb begin
    state_d = state_q;
    instr_d = NOP_WORD;
    valid_d = 1'b0;
    pop = 1'b0;
    stall_inc = 1'b0;
    if (state_q == S_IDLE) state_d = (start & ~halt) ? S_RUN : S_IDLE;
    else if (halt) state_d = S_IDLE;
    else if (empty) state_d = S_RUN;
    else if (haz) begin
      state_d = S_STALL;
      stall_inc = 1'b1;
    end else begin
      state_d = S_RUN;
      pop = 1'b1;
      instr_d = head;
      valid_d = 1'b1;
    end
  end

  // Registered state, issue outputs and wrapping statistics
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      iss_q <= '0;
      stl_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      iss_q <= iss_q + {{(CNT_W-1){1'b0}}, pop};
      stl_q <= stl_q + {{(CNT_W-1){1'b0}}, stall_inc};
    end

  // In-flight tracker: newest dest enters slot 0 and ages out after HAZARD_CYCLES; NOPs never enter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      trk_v_q <= '0;
      for (int i = 0; i < HAZARD_CYCLES; i++) trk_r_q[i] <= '0;
    end else begin
      trk_v_q[0] <= pop & (op != OP_NOP);
      trk_r_q[0] <= head[DST_LSB +: 8];
      for (int i = 1; i < HAZARD_CYCLES; i++) begin
        trk_v_q[i] <= trk_v_q[i-1];
        trk_r_q[i] <= trk_r_q[i-1];
      end
    end
endmodule

// File: tb/tb_proc_issue_seq.sv
// tb_proc_issue_seq: directed and random stimulus checked against a queue-and-timestamp model
module tb_proc_issue_seq;
  import proc_pkg::*;
  localparam int DEPTH = 8;
  localparam int HC = 2;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic halt = 1'b0;
  logic busy;
  logic [CW-1:0] issued_cnt, stall_cnt;
  proc_issue_seq_if bus();

  proc_issue_seq #(.DEPTH(DEPTH), .HAZARD_CYCLES(HC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .bus(bus),
    .busy(busy), .issued_cnt(issued_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] mq[$];
  bit m_run;
  logic [31:0] m_instr;
  bit m_valid;
  logic [CW-1:0] m_iss, m_stl;
  int cyc = 0;
  int busy_until [256];
  logic [7:0] ops [4] = '{8'h00, 8'h01, 8'h02, 8'hFF};

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // A register written at edge E is unreadable through edge E+HC
  function automatic bit hz(logic [31:0] w, int f);
    bit a = (w[31:24] == 8'h01 || w[31:24] == 8'h02) && f <= busy_until[w[15:8]];
    bit b = w[31:24] == 8'h02 && f <= busy_until[w[7:0]];
    return a || b;
  endfunction

  task automatic tick();
    bit acc = bus.in_valid && mq.size() < DEPTH;
    logic [31:0] w = bus.in_instr;
    m_instr = NOP_WORD;
    m_valid = 0;
    if (!m_run) m_run = start && !halt;
    else if (halt) m_run = 0;
    else if (mq.size() != 0) begin
      if (hz(mq[0], cyc)) m_stl++;
      else begin
        m_instr = mq.pop_front();
        m_valid = 1;
        m_iss++;
        if (m_instr[31:24] != 8'hFF) busy_until[m_instr[23:16]] = cyc + HC;
      end
    end
    if (acc) mq.push_back(w);
    @(posedge clk);
    cyc++;
    #1;
    chk("instr_out", bus.instr_out, m_instr);
    chk("issue_valid", bus.issue_valid, m_valid);
    chk("in_ready", bus.in_ready, mq.size() < DEPTH);
    chk("busy", busy, m_run);
    chk("issued_cnt", issued_cnt, m_iss);
    chk("stall_cnt", stall_cnt, m_stl);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 0;
    #1;
    mq.delete();
    m_run = 0;
    m_instr = NOP_WORD;
    m_valid = 0;
    m_iss = 0;
    m_stl = 0;
    foreach (busy_until[i]) busy_until[i] = -100;
    chk("rst_instr", bus.instr_out, 32'hFF00_0000);
    chk("rst_valid", bus.issue_valid, 0);
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_iss", issued_cnt, 0);
    chk("rst_stall", stall_cnt, 0);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic push(logic [31:0] w);
    bus.in_valid = 1;
    bus.in_instr = w;
    tick();
    bus.in_valid = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic pulse_halt();
    halt = 1;
    tick();
    halt = 0;
  endtask

  initial begin
    bus.in_valid = 0;
    bus.in_instr = '0;
    do_reset();
    // independent stream
    push(32'h0003_3964);
    push(32'h0104_3964);
    pulse_start();
    tick();
    chk("ind_first", bus.instr_out, 32'h0003_3964);
    tick();
    chk("ind_second", bus.instr_out, 32'h0104_3964);
    chk("ind_iss", issued_cnt, 2);
    chk("ind_stall", stall_cnt, 0);
    // RAW hazard: LOADI, two bubbles, ADDR
    pulse_halt();
    push(32'h0005_0003);
    push(32'h0206_3905);
    pulse_start();
    tick();
    chk("raw_loadi", bus.instr_out, 32'h0005_0003);
    tick();
    chk("raw_bub1", bus.issue_valid, 0);
    tick();
    chk("raw_bub2", bus.issue_valid, 0);
    tick();
    chk("raw_addr", bus.instr_out, 32'h0206_3905);
    chk("raw_stall", stall_cnt, 2);
    // full FIFO in IDLE
    pulse_halt();
    for (int i = 0; i < 9; i++) begin
      bus.in_valid = 1;
      bus.in_instr = {8'h00, 8'(8'h10 + i), 8'h00, 8'(i)};
      tick();
      if (i == 7) chk("full_ready", bus.in_ready, 0);
    end
    bus.in_valid = 0;
    pulse_start();
    for (int i = 0; i < 10; i++) tick();
    chk("full_iss", issued_cnt, 4'd12);
    // halt after 2 of 5, then resume
    pulse_halt();
    for (int i = 0; i < 5; i++) push({8'h00, 8'(8'h20 + i), 8'h00, 8'(i)});
    pulse_start();
    tick();
    tick();
    pulse_halt();
    chk("halt_busy", busy, 0);
    for (int i = 0; i < 3; i++) tick();
    pulse_start();
    tick();
    chk("resume_first", bus.instr_out, 32'h0022_0002);
    for (int i = 0; i < 3; i++) tick();
    start = 1;
    halt = 1;
    tick();
    start = 0;
    halt = 0;
    chk("start_halt_busy", busy, 0);
    // random traffic
    for (int n = 0; n < 400; n++) begin
      start = $urandom_range(0, 19) == 0;
      halt = $urandom_range(0, 29) == 0;
      bus.in_valid = $urandom_range(0, 1) == 1;
      bus.in_instr = {ops[$urandom_range(0, 3)], 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))};
      tick();
    end
    start = 0;
    halt = 0;
    bus.in_valid = 0;
    pulse_start();
    for (int i = 0; i < 30; i++) tick();
    // reset mid-RUN with 3 words queued
    pulse_halt();
    for (int i = 0; i < 5; i++) push({8'h00, 8'(8'h30 + i), 8'h00, 8'(i)});
    pulse_start();
    tick();
    tick();
    do_reset();
    pulse_start();
    for (int i = 0; i < 10; i++) tick();
    chk("post_rst_iss", issued_cnt, 0);
    // counter wrap: 17 issues in a 4-bit counter
    for (int i = 0; i < 17; i++) push({8'h00, 8'(8'h40 + i), 8'h00, 8'(i)});
    for (int i = 0; i < 5; i++) tick();
    chk("wrap_iss", issued_cnt, 4'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
